// File: rtl/fp_addsub_seq_if.sv
// Start/done handshake bundle for the sequential FP add/sub unit.
// master: start, sub, a, b out; sum, done, busy in. slave: mirrored.
interface fp_addsub_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         done;
    logic         busy;

    modport master (
        output start, sub, a, b,
        input  sum, done, busy
    );

    modport slave (
        input  start, sub, a, b,
        output sum, done, busy
    );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 add/sub, RNE rounding, full special handling.
// Ports: clk, reset (async, high), bus (slave: start/sub/a/b in,
// sum/done/busy out). Optional macro FPADD_DENORM_EN keeps subnormals;
// without it subnormal inputs read as zero and tiny results flush.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic            clk,
    input logic            reset,
    fp_addsub_seq_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 1;
    // working significand: carry, hidden, fraction, guard, round, sticky
    localparam int MW = MAN_W + 5;
    localparam int EW = EXP_W + 1;
    localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic          sa_q, sa_d;
    logic          sb_q, sb_d;
    logic [EW-1:0] ea_q, ea_d;
    logic [EW-1:0] eb_q, eb_d;
    logic [SW-1:0] ma_q, ma_d;
    logic [SW-1:0] mb_q, mb_d;
    logic [MW-1:0] mx_q, mx_d;
    logic [MW-1:0] my_q, my_d;
    logic [EW-1:0] ex_q, ex_d;
    logic          sr_q, sr_d;
    logic          esub_q, esub_d;
    logic [W-1:0]  spec_q, spec_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    // ---------------- operand classification ----------------
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] frac_a, frac_b;
    logic             sgn_a, sgn_b;
    logic             nan_a, nan_b;
    logic             inf_a, inf_b;
    logic             zero_a, zero_b;
    logic             special;
    logic [EW-1:0]    eff_a, eff_b;
    logic [SW-1:0]    sig_a, sig_b;
    logic [W-1:0]     spec_res;

    assign exp_a  = bus.a[W-2:MAN_W];
    assign exp_b  = bus.b[W-2:MAN_W];
    assign frac_a = bus.a[MAN_W-1:0];
    assign frac_b = bus.b[MAN_W-1:0];
    assign sgn_a  = bus.a[W-1];
    // subtraction is addition with b's sign flipped
    assign sgn_b  = bus.b[W-1] ^ bus.sub;

    assign nan_a = (&exp_a) & (|frac_a);
    assign nan_b = (&exp_b) & (|frac_b);
    assign inf_a = (&exp_a) & ~(|frac_a);
    assign inf_b = (&exp_b) & ~(|frac_b);

`ifdef FPADD_DENORM_EN
    assign zero_a = ~(|exp_a) & ~(|frac_a);
    assign zero_b = ~(|exp_b) & ~(|frac_b);
`else
    assign zero_a = ~(|exp_a);
    assign zero_b = ~(|exp_b);
`endif

    assign special = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;

    // subnormals sit at exponent 1 with a clear hidden bit
    assign eff_a = (|exp_a) ? {1'b0, exp_a} : EW'(1);
    assign eff_b = (|exp_b) ? {1'b0, exp_b} : EW'(1);
    assign sig_a = {|exp_a, frac_a};
    assign sig_b = {|exp_b, frac_b};

    always_comb begin
        spec_res = {sgn_a, exp_a, frac_a};
        if (nan_a || nan_b || (inf_a && inf_b && (sgn_a != sgn_b))) begin
            spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (inf_a) begin
            spec_res = {sgn_a, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (inf_b) begin
            spec_res = {sgn_b, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero_a && zero_b) begin
            spec_res = {sgn_a & sgn_b, {(W-1){1'b0}}};
        end else if (zero_a) begin
            spec_res = {sgn_b, exp_b, frac_b};
        end
    end

    // ---------------- alignment ----------------
    logic            a_big;
    logic [EW-1:0]   e_big, e_sml, e_diff, shamt;
    logic [SW-1:0]   m_big, m_sml;
    logic [2*MW-1:0] sml_wide;
    logic [MW-1:0]   sml_al;

    assign a_big  = {ea_q, ma_q} >= {eb_q, mb_q};
    assign e_big  = a_big ? ea_q : eb_q;
    assign e_sml  = a_big ? eb_q : ea_q;
    assign m_big  = a_big ? ma_q : mb_q;
    assign m_sml  = a_big ? mb_q : ma_q;
    assign e_diff = e_big - e_sml;
    // past MW every bit lands in the sticky bit anyway
    assign shamt  = (e_diff > EW'(MW)) ? EW'(MW) : e_diff;

    assign sml_wide = {1'b0, m_sml, 3'b000, {MW{1'b0}}} >> shamt;
    assign sml_al   = {sml_wide[2*MW-1:MW+1],
                       sml_wide[MW] | (|sml_wide[MW-1:0])};

    // ---------------- magnitude add ----------------
    logic [MW-1:0] add_raw, add_m;
    logic [EW-1:0] add_e;

    assign add_raw = esub_q ? (mx_q - my_q) : (mx_q + my_q);
    assign add_m   = add_raw[MW-1]
                   ? {1'b0, add_raw[MW-1:2], |add_raw[1:0]}
                   : add_raw;
    assign add_e   = add_raw[MW-1] ? (ex_q + EW'(1)) : ex_q;

    // ---------------- normalise ----------------
    logic norm_go;

    assign norm_go = (mx_q != '0) && !mx_q[MW-2] && (ex_q > EW'(1));

    // ---------------- round and pack ----------------
    logic             rnd_inc;
    logic [SW:0]      rnd;
    logic             rnd_hid;
    logic [MAN_W-1:0] rnd_frac;
    logic [EW-1:0]    rnd_exp;
    logic [W-1:0]     rnd_res;

    assign rnd_inc  = mx_q[2] & (mx_q[3] | mx_q[1] | mx_q[0]);
    assign rnd      = {1'b0, mx_q[MW-2:3]} + {{SW{1'b0}}, rnd_inc};
    assign rnd_hid  = rnd[SW] | rnd[SW-1];
    assign rnd_frac = rnd[SW] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    assign rnd_exp  = ex_q + EW'(rnd[SW]);

    always_comb begin
        rnd_res = {sr_q, rnd_exp[EXP_W-1:0], rnd_frac};
        if (mx_q == '0) begin
            rnd_res = '0;
        end else if (rnd_exp >= EMAX) begin
            rnd_res = {sr_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (!rnd_hid) begin
`ifdef FPADD_DENORM_EN
            // exponent floor is 1, so this is already subnormal form
            rnd_res = {sr_q, {EXP_W{1'b0}}, rnd_frac};
`else
            rnd_res = {sr_q, {(W-1){1'b0}}};
`endif
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            ex_q    <= '0;
            sr_q    <= 1'b0;
            esub_q  <= 1'b0;
            spec_q  <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            ex_q    <= ex_d;
            sr_q    <= sr_d;
            esub_q  <= esub_d;
            spec_q  <= spec_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        mx_d    = mx_q;
        my_d    = my_q;
        ex_d    = ex_q;
        sr_d    = sr_q;
        esub_d  = esub_q;
        spec_d  = spec_q;
        sum_d   = sum_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sa_d    = sgn_a;
                    sb_d    = sgn_b;
                    ea_d    = eff_a;
                    eb_d    = eff_b;
                    ma_d    = sig_a;
                    mb_d    = sig_b;
                    spec_d  = spec_res;
                    busy_d  = 1'b1;
                    state_d = special ? S_FIN : S_ALIGN;
                end
            end
            S_ALIGN: begin
                mx_d    = {1'b0, m_big, 3'b000};
                my_d    = sml_al;
                ex_d    = e_big;
                sr_d    = a_big ? sa_q : sb_q;
                esub_d  = sa_q ^ sb_q;
                state_d = S_ADD;
            end
            S_ADD: begin
                mx_d    = add_m;
                ex_d    = add_e;
                state_d = S_NORM;
            end
            S_NORM: begin
                if (norm_go) begin
                    mx_d = mx_q << 1;
                    ex_d = ex_q - EW'(1);
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                sum_d   = rnd_res;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_FIN: begin
                sum_d   = spec_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.sum  = sum_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed-vector bench for fp_addsub_seq (binary32 defaults).
// Checks results, handshake latency, reset abort and subnormal handling.
module tb_fp_addsub_seq;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    fp_addsub_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives start now; returns the result and the start-to-done
    // latency in cycles (-1 if done never arrives).
    task automatic run_op(input  logic [31:0] a,
                          input  logic [31:0] b,
                          input  logic        s,
                          output logic [31:0] r,
                          output int          lat);
        bus.a     = a;
        bus.b     = b;
        bus.sub   = s;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        r = bus.sum;
    endtask

    logic [31:0] r;
    int          lat;
    logic        seen;

    initial begin
        n_chk     = 0;
        n_err     = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #2;
        chk("rst_sum", bus.sum, 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 1.0 + 1.0, k = 0
        bus.a = 32'h3F800000;
        bus.b = 32'h3F800000;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_hi", 32'(bus.busy), 32'h1);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        chk("add_1p1", bus.sum, 32'h40000000);
        chk("lat_1p1", 32'(lat), 32'd4);
        @(posedge clk);
        #1;
        chk("busy_lo", 32'(bus.busy), 32'h0);
        chk("done_pulse", 32'(bus.done), 32'h0);
        chk("sum_hold", bus.sum, 32'h40000000);

        // back-to-back from here on: each op starts in the done cycle
        run_op(32'h3F800000, 32'h3F800000, 1'b1, r, lat);
        chk("sub_zero", r, 32'h00000000);
        chk("lat_zero", 32'(lat), 32'd4);
        run_op(32'h40400000, 32'h3F800000, 1'b1, r, lat);
        chk("sub_3m1", r, 32'h40000000);
        run_op(32'h3F800000, 32'h33800000, 1'b0, r, lat);
        chk("rne_tie", r, 32'h3F800000);
        run_op(32'h3F800001, 32'h33800000, 1'b0, r, lat);
        chk("rne_up", r, 32'h3F800002);
        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, r, lat);
        chk("ovf_inf", r, 32'h7F800000);
        run_op(32'h7F800000, 32'hFF800000, 1'b0, r, lat);
        chk("inf_minf", r, 32'h7FC00000);
        chk("lat_spec", 32'(lat), 32'd1);
        run_op(32'h7F800001, 32'h3F800000, 1'b0, r, lat);
        chk("nan_in", r, 32'h7FC00000);
        run_op(32'hFF800000, 32'h3F800000, 1'b0, r, lat);
        chk("inf_fin", r, 32'hFF800000);
        run_op(32'h3F800000, 32'h80000000, 1'b0, r, lat);
        chk("x_plus0", r, 32'h3F800000);
        run_op(32'h80000000, 32'h00000000, 1'b1, r, lat);
        chk("neg_zero", r, 32'h80000000);
        run_op(32'hC0000000, 32'h3F800000, 1'b0, r, lat);
        chk("neg_res", r, 32'hBF800000);
        // 1 ulp left: 23 normalise shifts
        run_op(32'h3F800001, 32'h3F800000, 1'b1, r, lat);
        chk("cancel", r, 32'h34000000);
        chk("lat_k23", 32'(lat), 32'd27);

        // reset in the middle of the long normalise
        bus.a = 32'h3F800001;
        bus.b = 32'hBF800000;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        chk("abort_sum", bus.sum, 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        reset = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        chk("abort_nodone", 32'(seen), 32'h0);
        run_op(32'h3F800000, 32'h3F800000, 1'b0, r, lat);
        chk("after_abort", r, 32'h40000000);

        run_op(32'h00000001, 32'h00000001, 1'b0, r, lat);
`ifdef FPADD_DENORM_EN
        chk("subnorm", r, 32'h00000002);
`else
        chk("subnorm", r, 32'h00000000);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
